fifo_wptr_full: RTL

//  Write-side pointer and full-flag controller of the async FIFO. Sits directly upstream
//  of the dual-port FIFO RAM and drives its write address and write enable.

---
 rtl/fifo_wptr_full.sv | 92 +++++++++
 1 files changed

// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full: write-side pointer and full-flag controller of an async FIFO.
//   Latency: RAM write enable/address are combinational (0 cycles); flags and pointers update on the push edge.
//   Backpressure: wfull blocks pushes; a write attempted while full is dropped and sets the sticky wovf.
// Ports:
//   w_clk, w_rst      write clock, synchronous active-low reset
//   winc              write request from producer
//   rptr_gray         Gray read pointer from the read domain (asynchronous)
//   wclken, waddr     RAM write enable and address
//   wptr_gray         registered Gray write pointer to the read-domain synchronizer
//   wfull, walmost_full, wlevel, wovf   status flags (registered)
module fifo_wptr_full #(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_MARGIN  = 2
) (
  input  logic                  w_clk,
  input  logic                  w_rst,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   rptr_gray,
  output logic                  wclken,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  wovf
);

  localparam int A     = ADDR_WIDTH;
  localparam int DEPTH = 1 << A;
  localparam logic [A:0] AF_THRESH = (A+1)'(DEPTH - AF_MARGIN);

  logic [A:0] wbin_q, wbin_d;
  logic [A:0] wgray_q, wgray_d;
  logic [A:0] rq1_q, rq2_q;
  logic [A:0] rbin;
  logic [A:0] level_d;
  logic       wfull_q, wfull_d;
  logic       waf_q, waf_d;
  logic [A:0] wlevel_q;
  logic       wovf_q, wovf_d;
  logic       push;

  always_comb begin
    push    = winc & ~wfull_q;
    wbin_d  = wbin_q + {{A{1'b0}}, push};
    wgray_d = wbin_d ^ (wbin_d >> 1);

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    rbin = '0;
    for (int i = 0; i <= A; i++) begin
      rbin[i] = ^(rq2_q >> i);
    end

    level_d = wbin_d - rbin;
    // Full when the next write pointer is exactly one lap ahead of the synced
    // read pointer: in Gray, the top two bits are inverted and the rest match.
    wfull_d = (wgray_d == {~rq2_q[A:A-1], rq2_q[A-2:0]});
    waf_d   = (level_d >= AF_THRESH);
    wovf_d  = wovf_q | (winc & wfull_q);
  end

  always_ff @(posedge w_clk) begin
    if (!w_rst) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      rq1_q    <= '0;
      rq2_q    <= '0;
      wfull_q  <= 1'b0;
      waf_q    <= 1'b0;
      wlevel_q <= '0;
      wovf_q   <= 1'b0;
    end else begin
      rq1_q    <= rptr_gray;
      rq2_q    <= rq1_q;
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      wfull_q  <= wfull_d;
      waf_q    <= waf_d;
      wlevel_q <= level_d;
      wovf_q   <= wovf_d;
    end
  end

  assign wclken       = push;
  assign waddr        = wbin_q[A-1:0];
  assign wptr_gray    = wgray_q;
  assign wfull        = wfull_q;
  assign walmost_full = waf_q;
  assign wlevel       = wlevel_q;
  assign wovf         = wovf_q;

endmodule
